// File: rtl/imdct_twiddle_seq_if.sv
// Twiddle stream interface between the IMDCT twiddle sequencer and the butterfly datapath.
//   tw_valid : twiddle available (sequencer -> consumer)
//   tw_ready : consumer accepts (consumer -> sequencer)
//   tw_cos   : cos(theta)/2, Q1.31
//   tw_sin   : sin(theta)/2, Q1.31
interface imdct_twiddle_seq_if #(
    parameter int unsigned DW = 32
);
    logic          tw_valid;
    logic          tw_ready;
    logic [DW-1:0] tw_cos;
    logic [DW-1:0] tw_sin;

    modport master (
        output tw_valid,
        output tw_cos,
        output tw_sin,
        input  tw_ready
    );

    modport slave (
        input  tw_valid,
        input  tw_cos,
        input  tw_sin,
        output tw_ready
    );
endinterface

// File: rtl/imdct_twiddle_seq.sv
// IMDCT twiddle sequencer.
// Generates count indices n_i = (base + i*step) mod 2^IDX_W, reads the octant-folded twiddle ROM
// and reconstructs cos(theta)/2, sin(theta)/2 for theta = n*2*pi/2^IDX_W.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start             : job request, sampled only while idle
//   base, step, count : first index, stride, number of twiddles (0..2^IDX_W)
//   rom_en, rom_addr  : ROM read request (registered ROM, 1-cycle latency)
//   rom_dout          : ROM entry {U, L}, U = (cos phi + sin phi)/2, L = sin phi/2
//   tw                : twiddle stream (valid/ready, cos, sin)
//   busy, done        : job in progress, one-cycle pulse after the last twiddle is accepted
module imdct_twiddle_seq #(
    parameter int unsigned IDX_W = 11,
    parameter int unsigned DW    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [IDX_W-1:0]     base,
    input  logic [IDX_W-1:0]     step,
    input  logic [IDX_W:0]       count,
    output logic                 rom_en,
    output logic [IDX_W-3:0]     rom_addr,
    input  logic [2*DW-1:0]      rom_dout,
    imdct_twiddle_seq_if.master  tw,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned RW = IDX_W - 3;  // offset-within-octant width
    localparam int unsigned AW = RW + 1;     // ROM address width (0..2^RW)

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  step_q, step_d;
    logic [IDX_W:0]    count_q, count_d;
    logic [IDX_W:0]    issued_q, issued_d;
    logic [IDX_W:0]    accepted_q, accepted_d;
    // Fold stage: folded address and octant of the next index to be issued.
    logic [AW-1:0]     addr_q, addr_d;
    logic [2:0]        addr_oct_q, addr_oct_d;
    logic              addr_v_q, addr_v_d;
    // ROM output stage.
    logic              s1_v_q, s1_v_d;
    logic [2:0]        s1_oct_q, s1_oct_d;
    // Output stage.
    logic              tw_valid_q, tw_valid_d;
    logic [DW-1:0]     tw_cos_q, tw_cos_d;
    logic [DW-1:0]     tw_sin_q, tw_sin_d;
    logic              done_q, done_d;

    logic              run;
    logic              adv;
    logic              issue;
    logic              fold_ld;
    logic              hs;
    logic              load;
    logic              last_hs;
    logic [DW-1:0]     rom_u;
    logic [DW-1:0]     rom_l;
    logic [DW-1:0]     val_c;
    logic [DW-1:0]     val_s;
    logic [DW-1:0]     neg_c;
    logic [DW-1:0]     neg_s;

    // Odd octants are mirrored about their upper edge: k = 2^RW - r, giving 1..2^RW.
    function automatic logic [AW-1:0] fold_addr(input logic [IDX_W-1:0] n);
        logic [AW-1:0] r;
        r = {1'b0, n[RW-1:0]};
        if (n[RW]) begin
            fold_addr = AW'(1 << RW) - r;
        end else begin
            fold_addr = r;
        end
    endfunction

    always_comb begin
        run     = (state_q == StRun);
        adv     = !tw_valid_q || tw.tw_ready;
        issue   = run && addr_v_q && (issued_q < count_q) && adv;
        fold_ld = run && (!addr_v_q || issue);
        hs      = tw_valid_q && tw.tw_ready;
        load    = adv && s1_v_q;
        last_hs = hs && (accepted_q == count_q - 1'b1);

        rom_u = rom_dout[2*DW-1:DW];
        rom_l = rom_dout[DW-1:0];
        val_c = rom_u - rom_l;
        val_s = rom_l;
        neg_c = '0 - val_c;
        neg_s = '0 - val_s;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        step_d     = step_q;
        count_d    = count_q;
        issued_d   = issued_q;
        accepted_d = accepted_q;
        addr_d     = addr_q;
        addr_oct_d = addr_oct_q;
        addr_v_d   = addr_v_q;
        s1_v_d     = s1_v_q;
        s1_oct_d   = s1_oct_q;
        tw_valid_d = tw_valid_q;
        tw_cos_d   = tw_cos_q;
        tw_sin_d   = tw_sin_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StRun;
                    idx_d      = base;
                    step_d     = step;
                    count_d    = count;
                    issued_d   = '0;
                    accepted_d = '0;
                    addr_v_d   = 1'b0;
                end
            end
            StRun: begin
                if ((count_q == '0) || last_hs) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // The fold register is primed once on entry, then refilled on every issue.
        if (fold_ld) begin
            addr_d     = fold_addr(idx_q);
            addr_oct_d = idx_q[IDX_W-1 -: 3];
            addr_v_d   = 1'b1;
            idx_d      = idx_q + step_q;
        end

        if (issue) begin
            issued_d = issued_q + 1'b1;
            s1_oct_d = addr_oct_q;
        end

        // ROM data is held while rom_en is low, so s1 simply waits under backpressure.
        if (issue) begin
            s1_v_d = 1'b1;
        end else if (adv) begin
            s1_v_d = 1'b0;
        end

        if (hs) begin
            accepted_d = accepted_q + 1'b1;
        end

        if (load) begin
            tw_valid_d = 1'b1;
            unique case (s1_oct_q)
                3'd0: begin tw_cos_d = val_c; tw_sin_d = val_s; end
                3'd1: begin tw_cos_d = val_s; tw_sin_d = val_c; end
                3'd2: begin tw_cos_d = neg_s; tw_sin_d = val_c; end
                3'd3: begin tw_cos_d = neg_c; tw_sin_d = val_s; end
                3'd4: begin tw_cos_d = neg_c; tw_sin_d = neg_s; end
                3'd5: begin tw_cos_d = neg_s; tw_sin_d = neg_c; end
                3'd6: begin tw_cos_d = val_s; tw_sin_d = neg_c; end
                3'd7: begin tw_cos_d = val_c; tw_sin_d = neg_s; end
                default: begin tw_cos_d = val_c; tw_sin_d = val_s; end
            endcase
        end else if (hs) begin
            tw_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            step_q     <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            addr_q     <= '0;
            addr_oct_q <= '0;
            addr_v_q   <= 1'b0;
            s1_v_q     <= 1'b0;
            s1_oct_q   <= '0;
            tw_valid_q <= 1'b0;
            tw_cos_q   <= '0;
            tw_sin_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            step_q     <= step_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            addr_q     <= addr_d;
            addr_oct_q <= addr_oct_d;
            addr_v_q   <= addr_v_d;
            s1_v_q     <= s1_v_d;
            s1_oct_q   <= s1_oct_d;
            tw_valid_q <= tw_valid_d;
            tw_cos_q   <= tw_cos_d;
            tw_sin_q   <= tw_sin_d;
            done_q     <= done_d;
        end
    end

    assign rom_en      = issue;
    assign rom_addr    = addr_q;
    assign tw.tw_valid = tw_valid_q;
    assign tw.tw_cos   = tw_cos_q;
    assign tw.tw_sin   = tw_sin_q;
    assign busy        = run;
    assign done        = done_q;

endmodule
